fb_arbiter: RTL and testbench
=============================

Name: fb_arbiter

Overview:
- Shares the single-port 1-bit framebuffer between two requesters: the capture write side (pixels decoded from the STN panel bus) and the display read side (pixel generator fetches for HDMI scan-out).
- The display read side has absolute priority and a fixed read latency.
- Capture writes are buffered in a small FIFO and drained into idle memory cycles.
- Overflows are flagged and counted for debug; the capture side cannot be stalled.

Parameters:
- ADDR_W, 19, framebuffer address width.
- FIFO_DEPTH, 4, write FIFO entries; must be a power of 2, minimum 2.
- DROP_W, 16, width of the saturating dropped-write counter.

Ports:
- clk  in  1  pixel/system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_req  in  1  display read request; one request per cycle.
- rd_addr  in  ADDR_W  display read address.
- rd_valid  out  1  read data valid; returned exactly 2 cycles after rd_req.
- rd_data  out  1  read pixel data.
- wr_valid  in  1  capture write strobe; no backpressure.
- wr_addr  in  ADDR_W  capture write address.
- wr_data  in  1  capture pixel bit.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  1  RAM write data (registered).
- mem_rdata  in  1  RAM read data; valid 1 cycle after the registered address.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_flag  out  1  sticky; set on the first dropped write.
- drop_count  out  DROP_W  saturating count of dropped writes.
- clr_stats  in  1  synchronous clear of drop_flag and drop_count.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: mem_we=0, mem_addr=0, mem_wdata=0, rd_valid=0, rd_data=0, fifo_level=0, drop_flag=0, drop_count=0.
  - FIFO pointers cleared; grant state = IDLE.
  - Reset mid-operation discards all FIFO contents and in-flight reads; no rd_valid is produced for reads issued before reset.
- Grant FSM, evaluated each cycle:
  - IDLE, READ and WRITE are the grant issued into the memory register stage for the next cycle.
  - rd_req=1 → READ: mem_addr<=rd_addr, mem_we<=0.
  - Else if FIFO not empty → WRITE: pop head, mem_addr<=head.addr, mem_wdata<=head.data, mem_we<=1.
  - Else → IDLE: mem_we<=0, mem_addr holds its previous value.
  - Any state may go to any other state every cycle; there is no multi-cycle ownership.
- Read latency:
  - Cycle 0: rd_req sampled. Cycle 1: RAM address registered. Cycle 2: rd_valid=1 and rd_data=mem_rdata (registered).
  - Implemented as a 2-stage valid shift; back-to-back reads give back-to-back rd_valid, in order.
- FIFO:
  - Push when wr_valid=1 and (FIFO not full, or a pop occurs in the same cycle).
  - Simultaneous push and pop on a full FIFO: both happen, level unchanged, no drop.
  - Simultaneous push and pop on an empty FIFO: no bypass. The entry is written into the FIFO and popped on a later cycle, so the minimum write latency is 2 cycles from wr_valid to mem_we.
  - Ordering is preserved: writes reach memory in arrival order.
- Drops:
  - A drop occurs when wr_valid=1, the FIFO is full and no pop occurs that cycle. The write is discarded and the FIFO is unchanged.
  - On a drop: drop_flag<=1; drop_count increments, saturating at all-ones.
  - If clr_stats and a drop occur in the same cycle, clear wins and the drop is not counted.
- Read/write hazard:
  - A read to an address with a write pending in the FIFO returns the old RAM contents; there is no forwarding. This is acceptable for display.
- fifo_level is registered and reflects occupancy after the current cycle's push/pop.

Test Plan:
- Reset mid-operation: 3 entries in the FIFO plus 2 reads in flight, assert rst_n=0 → fifo_level=0, mem_we=0, no rd_valid for 3 cycles after release.
- Reads only: rd_req at addr 0x00010..0x00013 on consecutive cycles with RAM preloaded 1,0,1,1 → rd_valid high on cycles 2..5 with rd_data 1,0,1,1.
- Write drain while idle: single wr_valid at addr 0x12345, data=1, rd_req=0 → mem_we=1, mem_addr=0x12345, mem_wdata=1 exactly 2 cycles later; fifo_level goes 1 then 0.
- Priority: rd_req held high for 10 cycles while 4 writes arrive → mem_we stays 0 throughout and fifo_level=4. After rd_req drops, 4 consecutive write cycles in arrival order, then level=0.
- Overflow: FIFO full, rd_req=1, 3 further wr_valid → drop_flag=1, drop_count=3, FIFO contents unchanged. clr_stats together with a 4th drop → drop_count=0, drop_flag=0.
- Full plus simultaneous pop: FIFO full, rd_req=0, wr_valid=1 → no drop, level stays 4, popped entry written to RAM.

Source files
------------

// File: rtl/fb_arbiter_if.sv
// Bus bundle between the framebuffer arbiter, its two requesters and the single-port RAM.
interface fb_arbiter_if #(
  parameter int ADDR_W = 19
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              rd_data;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_wdata;
  logic              mem_rdata;

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output rd_valid, rd_data, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  rd_valid, rd_data, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Framebuffer port arbiter: display reads win every cycle, capture writes queue in a
// small FIFO and drain into idle memory cycles; writes that find the FIFO full are dropped.
module fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  fb_arbiter_if.slave                   bus,
  input  logic                          clr_stats,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          drop_flag,
  output logic [DROP_W-1:0]             drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Bit 0 marks a read in the memory stage, bit 1 a write, so both drive outputs directly.
  localparam logic [1:0] GNT_IDLE  = 2'b00;
  localparam logic [1:0] GNT_READ  = 2'b01;
  localparam logic [1:0] GNT_WRITE = 2'b10;

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fb_arbiter: FIFO_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic              fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;
  logic [1:0]        gnt_q;
  logic [1:0]        gnt_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_wdata_q;
  logic              rd_valid_q;
  logic              rd_data_q;
  logic              drop_flag_q;
  logic [DROP_W-1:0] drop_count_q;
  logic              empty_s;
  logic              full_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;

  // Grant selection and FIFO push/pop/drop decisions for this cycle.
  always_comb begin
    empty_s = (level_q == {LVL_W{1'b0}});
    full_s  = (level_q == LVL_W'(FIFO_DEPTH));
    if (bus.rd_req) begin
      gnt_d = GNT_READ;
    end else if (!empty_s) begin
      gnt_d = GNT_WRITE;
    end else begin
      gnt_d = GNT_IDLE;
    end
    pop_s   = (gnt_d == GNT_WRITE);
    push_s  = bus.wr_valid && (!full_s || pop_s);
    drop_s  = bus.wr_valid && full_s && !pop_s;
    level_d = level_q + {{(LVL_W-1){1'b0}}, push_s} - {{(LVL_W-1){1'b0}}, pop_s};
  end

  // Write FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= {ADDR_W{1'b0}};
        fifo_data_q[i] <= 1'b0;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_addr_q[wr_ptr_q] <= bus.wr_addr;
        fifo_data_q[wr_ptr_q] <= bus.wr_data;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q <= level_d;
    end
  end

  // Memory register stage; address and data hold when no grant is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= GNT_IDLE;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 1'b0;
    end else begin
      gnt_q <= gnt_d;
      case (gnt_d)
        GNT_READ: begin
          mem_addr_q <= bus.rd_addr;
        end
        GNT_WRITE: begin
          mem_addr_q  <= fifo_addr_q[rd_ptr_q];
          mem_wdata_q <= fifo_data_q[rd_ptr_q];
        end
        default: begin
          mem_addr_q <= mem_addr_q;
        end
      endcase
    end
  end

  // Read return: second stage of the read valid shift, capturing RAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= 1'b0;
    end else begin
      rd_valid_q <= gnt_q[0];
      if (gnt_q[0]) begin
        rd_data_q <= bus.mem_rdata;
      end
    end
  end

  // Sticky drop flag and saturating drop counter; clear beats a coincident drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_flag_q  <= 1'b0;
      drop_count_q <= {DROP_W{1'b0}};
    end else if (clr_stats) begin
      drop_flag_q  <= 1'b0;
      drop_count_q <= {DROP_W{1'b0}};
    end else if (drop_s) begin
      drop_flag_q <= 1'b1;
      if (drop_count_q != {DROP_W{1'b1}}) begin
        drop_count_q <= drop_count_q + DROP_W'(1);
      end
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = gnt_q[1];
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign fifo_level    = level_q;
  assign drop_flag     = drop_flag_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: table of per-cycle vectors plus hand sequences for
// overflow, full-with-pop and reset in mid-operation, against a behavioural RAM.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_stats;
  logic [2:0]  fifo_level;
  logic        drop_flag;
  logic [15:0] drop_count;

  logic        pre_we;
  logic [18:0] pre_addr;
  logic        pre_data;
  bit          ram [0:524287];

  int n_vec = 0;
  int n_err = 0;

  fb_arbiter_if #(.ADDR_W(19)) bus ();

  fb_arbiter #(.ADDR_W(19), .FIFO_DEPTH(4), .DROP_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_stats  (clr_stats),
    .fifo_level (fifo_level),
    .drop_flag  (drop_flag),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = ram[bus.mem_addr];

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
  end

  typedef struct {
    logic        rd;
    logic [18:0] ra;
    logic        wv;
    logic [18:0] wa;
    logic        wd;
    logic        we;
    logic [18:0] ma;
    logic        mwd;
    logic        rv;
    logic        rdat;
    logic [2:0]  lvl;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic rd, input int ra, input logic wv, input int wa,
                              input logic wd, input logic we, input int ma, input logic mwd,
                              input logic rv, input logic rdat, input int lvl);
    vec_t v;
    v.rd = rd; v.ra = 19'(ra); v.wv = wv; v.wa = 19'(wa); v.wd = wd;
    v.we = we; v.ma = 19'(ma); v.mwd = mwd; v.rv = rv; v.rdat = rdat; v.lvl = 3'(lvl);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input int ra, input logic wv, input int wa,
                       input logic wd, input logic clr);
    bus.rd_req   = rd;
    bus.rd_addr  = 19'(ra);
    bus.wr_valid = wv;
    bus.wr_addr  = 19'(wa);
    bus.wr_data  = wd;
    clr_stats    = clr;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [3:0] pat;
    pat = 4'b1101;
    rst_n  = 1'b0;
    pre_we = 1'b0; pre_addr = 19'd0; pre_data = 1'b0;
    drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    // Preload RAM 0x10..0x13 with 1,0,1,1 while the DUT is held in reset.
    for (int k = 0; k < 4; k++) begin
      pre_we = 1'b1; pre_addr = 19'(16 + k); pre_data = pat[k];
      tick();
    end
    pre_we = 1'b0;
    tick();
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst fifo_level", 32'(fifo_level), 32'd0);
    chk("rst drop_flag", 32'(drop_flag), 32'd0);
    chk("rst drop_count", 32'(drop_count), 32'd0);
    rst_n = 1'b1;

    // Reads, idle write drain, then read priority over four queued writes.
    tbl.push_back(mk(1, 'h10, 0, 0, 0,   0, 'h10, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h11, 0, 0, 0,   0, 'h11, 0, 1, 1, 0));
    tbl.push_back(mk(1, 'h12, 0, 0, 0,   0, 'h12, 0, 1, 0, 0));
    tbl.push_back(mk(1, 'h13, 0, 0, 0,   0, 'h13, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,      0, 'h13, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,      0, 'h13, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 'h12345, 1, 0, 'h13, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,      1, 'h12345, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,      0, 'h12345, 1, 0, 1, 0));
    tbl.push_back(mk(1, 'h20, 1, 'h100, 1, 0, 'h20, 1, 0, 1, 1));
    tbl.push_back(mk(1, 'h20, 1, 'h101, 0, 0, 'h20, 1, 1, 0, 2));
    tbl.push_back(mk(1, 'h20, 1, 'h102, 1, 0, 'h20, 1, 1, 0, 3));
    tbl.push_back(mk(1, 'h20, 1, 'h103, 1, 0, 'h20, 1, 1, 0, 4));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(1, 'h20, 0, 0, 0, 0, 'h20, 1, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0,      1, 'h100, 1, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0,      1, 'h101, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0,      1, 'h102, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,      1, 'h103, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,      0, 'h103, 1, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rd, int'(tbl[i].ra), tbl[i].wv, int'(tbl[i].wa), tbl[i].wd, 1'b0);
      tick();
      chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(tbl[i].we));
      chk($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), 32'(tbl[i].ma));
      chk($sformatf("v%0d mem_wdata", i), 32'(bus.mem_wdata), 32'(tbl[i].mwd));
      chk($sformatf("v%0d rd_valid", i), 32'(bus.rd_valid), 32'(tbl[i].rv));
      chk($sformatf("v%0d rd_data", i), 32'(bus.rd_data), 32'(tbl[i].rdat));
      chk($sformatf("v%0d fifo_level", i), 32'(fifo_level), 32'(tbl[i].lvl));
    end

    // Overflow: fill under read priority, then three drops.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 'h20, 1'b1, 'h200 + k, k[0], 1'b0);
      tick();
      chk($sformatf("fill%0d level", k), 32'(fifo_level), 32'(k + 1));
      chk($sformatf("fill%0d mem_we", k), 32'(bus.mem_we), 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 'h20, 1'b1, 'h2F0, 1'b1, 1'b0);
      tick();
      chk($sformatf("drop%0d level", k), 32'(fifo_level), 32'd4);
      chk($sformatf("drop%0d flag", k), 32'(drop_flag), 32'd1);
      chk($sformatf("drop%0d count", k), 32'(drop_count), 32'(k + 1));
      chk($sformatf("drop%0d mem_we", k), 32'(bus.mem_we), 32'd0);
    end
    drive(1'b1, 'h20, 1'b1, 'h2F0, 1'b1, 1'b1);
    tick();
    chk("clr+drop count", 32'(drop_count), 32'd0);
    chk("clr+drop flag", 32'(drop_flag), 32'd0);
    chk("clr+drop level", 32'(fifo_level), 32'd4);

    // Full FIFO with a pop in the same cycle accepts the write.
    drive(1'b0, 0, 1'b1, 'h300, 1'b1, 1'b0);
    tick();
    chk("fullpop mem_we", 32'(bus.mem_we), 32'd1);
    chk("fullpop mem_addr", 32'(bus.mem_addr), 32'h200);
    chk("fullpop mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("fullpop level", 32'(fifo_level), 32'd4);
    chk("fullpop flag", 32'(drop_flag), 32'd0);
    chk("fullpop count", 32'(drop_count), 32'd0);
    drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic [18:0] ea;
      logic        ed;
      ea = (k == 3) ? 19'h300 : 19'(32'h201 + k);
      ed = (k == 1) ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("drain%0d mem_we", k), 32'(bus.mem_we), 32'd1);
      chk($sformatf("drain%0d mem_addr", k), 32'(bus.mem_addr), 32'(ea));
      chk($sformatf("drain%0d mem_wdata", k), 32'(bus.mem_wdata), 32'(ed));
      chk($sformatf("drain%0d level", k), 32'(fifo_level), 32'(3 - k));
    end

    // Read back a drained address and the dropped address.
    drive(1'b1, 'h201, 1'b0, 0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 'h2F0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    chk("rb201 valid", 32'(bus.rd_valid), 32'd1);
    chk("rb201 data", 32'(bus.rd_data), 32'd1);
    drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    tick();
    chk("rb2F0 valid", 32'(bus.rd_valid), 32'd1);
    chk("rb2F0 data", 32'(bus.rd_data), 32'd0);
    tick();
    chk("rb end valid", 32'(bus.rd_valid), 32'd0);

    // Reset with three queued writes and reads in flight.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 'h10, 1'b1, 'h400 + k, 1'b1, 1'b0);
      tick();
    end
    chk("pre-rst level", 32'(fifo_level), 32'd3);
    chk("pre-rst rd_valid", 32'(bus.rd_valid), 32'd1);
    drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midrst level", 32'(fifo_level), 32'd0);
    chk("midrst mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("midrst mem_addr", 32'(bus.mem_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("postrst%0d rd_valid", k), 32'(bus.rd_valid), 32'd0);
      chk($sformatf("postrst%0d mem_we", k), 32'(bus.mem_we), 32'd0);
      chk($sformatf("postrst%0d level", k), 32'(fifo_level), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
